first_nios2_system_sysid_checker: RTL and testbench
===================================================

# first_nios2_system_sysid_checker

Boot-time consumer of the system ID slave: an Avalon-MM read master that, after reset or on request, reads the ID word (address 0) and the timestamp word (address 1) from the sysid control slave. It compares both against build-time expected values and publishes match, timeout and captured-value status to the board-management logic. It sits directly downstream of the sysid slave on a private point-to-point Avalon link.

## Interface
Parameters:
- EXPECTED_ID, 32'h0000_1234: ID word required at address 0.
- EXPECTED_TIMESTAMP, 32'h50AE_2FFE: timestamp word required at address 1.
- TIMEOUT_CYCLES, 16: maximum consecutive waitrequest-high cycles per read; 0 disables the timeout.

Ports:
- clock  in  1  sole clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to re-run the check.
- avm_address  out  1  0 = ID word, 1 = timestamp word.
- avm_read  out  1  read strobe, held until accepted.
- avm_readdata  in  32  sampled on the accepting edge.
- avm_waitrequest  in  1  slave stall.
- busy  out  1  check in progress.
- done  out  1  check finished; level, held until the next check starts.
- id_match  out  1  captured ID == EXPECTED_ID.
- ts_match  out  1  captured timestamp == EXPECTED_TIMESTAMP.
- timeout  out  1  last check aborted on timeout.
- id_value  out  32  last captured ID word.
- ts_value  out  32  last captured timestamp word.

## Operation
- FSM states: IDLE, RD_ID, RD_TS, DONE. Reset state is IDLE with the internal boot flag set to 1.
- IDLE -> RD_ID when boot=1 or start=1. Boot clears on leaving IDLE.
- RD_ID: avm_read=1, avm_address=0. On an edge with avm_waitrequest=0, capture id_value and go to RD_TS.
- RD_TS: avm_read=1, avm_address=1. On the accepting edge, capture ts_value and go to DONE.
- DONE: done=1. start=1 clears done, id_match, ts_match and timeout, then enters RD_ID on the same edge.
- id_match and ts_match are registered. They update on the edge that enters DONE and are 0 while busy.
- Timeout: a per-read counter of width $clog2(TIMEOUT_CYCLES+1) counts cycles with avm_read=1 and avm_waitrequest=1. It clears on every transfer acceptance and on every state entry. When the count reaches TIMEOUT_CYCLES:
  - the FSM goes to DONE with timeout=1 and id_match=ts_match=0;
  - avm_read drops;
  - values captured before the abort are kept and the rest are left unchanged.
- If waitrequest falls on the same edge the counter would expire, acceptance wins and no timeout occurs.
- start while busy=1 is ignored. start in IDLE when boot=0 is unreachable, because IDLE is left immediately after reset.
- All outputs reset to 0, including id_value and ts_value. avm_address and avm_read are registered.
- Reset mid-transfer drops avm_read asynchronously and returns to IDLE with boot=1, so the check restarts.

## Timing
- Zero-wait-state slave:
  - edge 1 after reset release: IDLE -> RD_ID, and read asserts;
  - edge 2: ID captured;
  - edge 3: timestamp captured, and done, id_match, ts_match are valid after edge 3.
- Each wait state adds exactly one cycle to its read.
- busy=1 exactly in RD_ID and RD_TS.
- avm_address and avm_read are stable while waitrequest=1 (Avalon hold rule).
- With start in DONE, read asserts the cycle after the start edge.

## Configuration
- SYSID_CHECKER_TIMESTAMP_EN defined: full behaviour as above.
- Not defined:
  - the RD_TS state is not built, and RD_ID goes straight to DONE (done valid after edge 2);
  - ts_value is constant 0 and ts_match is constant 1 whenever done=1;
  - EXPECTED_TIMESTAMP is unused.

## Test plan
- Boot match: slave returns 0x00001234 at address 0 and 0x50AE2FFE at address 1 with no wait states -> reads on edges 2 and 3, done=1, id_match=1, ts_match=1, timeout=0 after edge 3.
- Timestamp mismatch: address 1 returns 0x50AE2FFF -> id_match=1, ts_match=0, ts_value=0x50AE2FFF.
- Wait states: 3 waitrequest cycles on each read -> done after edge 9, address and read held stable, both matches set.
- Timeout: waitrequest stuck at 1 on the ID read -> after 16 stalled cycles, done=1, timeout=1, avm_read=0, id_value=0. Waitrequest falling on cycle 16 instead -> normal completion with timeout=0.
- Re-check and ignore: start pulsed mid-read is ignored. start in DONE clears flags, and the next check completes with fresh values. Reset asserted during RD_TS -> outputs 0 immediately and the check reruns after release.
- Macro off: one read only, done after edge 2, ts_match=1, ts_value=0.

Source files
------------

// File: rtl/first_nios2_system_sysid_checker.sv
// Boot-time Avalon-MM reader that fetches the sysid ID (and optionally timestamp) word and checks it.
// Define SYSID_CHECKER_TIMESTAMP_EN to also read and check the timestamp word at address 1.
module first_nios2_system_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'h0000_1234,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h50AE_2FFE,
  parameter int unsigned TIMEOUT_CYCLES     = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        id_match,
  output logic        ts_match,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  // Avalon read handshake: avm_read/avm_address are raised together and held unchanged
  // until an edge with avm_waitrequest=0; that accepting edge samples avm_readdata.
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

`ifdef SYSID_CHECKER_TIMESTAMP_EN
  localparam logic TS_ON_ABORT = 1'b0;
`else
  localparam logic TS_ON_ABORT = 1'b1;
`endif

  typedef enum logic [1:0] {IDLE, RD_ID, RD_TS, DONE} state_t;

  state_t           state_q, state_n;
  logic             boot_q, boot_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             read_n, addr_n, done_n, id_match_n, ts_match_n, timeout_n;
  logic [31:0]      id_value_n;
  logic             expire;

  // A read aborts on the stalled cycle that would make the count reach TIMEOUT_CYCLES.
  assign expire = (TIMEOUT_CYCLES != 0) && avm_waitrequest &&
                  (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign busy   = (state_q == RD_ID) || (state_q == RD_TS);

`ifdef SYSID_CHECKER_TIMESTAMP_EN
  logic [31:0] ts_value_q, ts_value_n;
  assign ts_value = ts_value_q;
`else
  logic unused_ts;
  assign unused_ts = ^EXPECTED_TIMESTAMP;
  assign ts_value  = '0;
`endif

  always_comb begin
    state_n    = state_q;
    boot_n     = boot_q;
    cnt_n      = '0;
    read_n     = avm_read;
    addr_n     = avm_address;
    done_n     = done;
    id_match_n = id_match;
    ts_match_n = ts_match;
    timeout_n  = timeout;
    id_value_n = id_value;
`ifdef SYSID_CHECKER_TIMESTAMP_EN
    ts_value_n = ts_value_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (boot_q || start) begin
          state_n = RD_ID;
          boot_n  = 1'b0;
          read_n  = 1'b1;
          addr_n  = 1'b0;
        end
      end
      RD_ID: begin
        if (!avm_waitrequest) begin
          id_value_n = avm_readdata;
`ifdef SYSID_CHECKER_TIMESTAMP_EN
          state_n    = RD_TS;
          addr_n     = 1'b1;
`else
          state_n    = DONE;
          read_n     = 1'b0;
          done_n     = 1'b1;
          id_match_n = (avm_readdata == EXPECTED_ID);
          ts_match_n = 1'b1;
`endif
        end else if (expire) begin
          state_n    = DONE;
          read_n     = 1'b0;
          addr_n     = 1'b0;
          done_n     = 1'b1;
          timeout_n  = 1'b1;
          id_match_n = 1'b0;
          ts_match_n = TS_ON_ABORT;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
`ifdef SYSID_CHECKER_TIMESTAMP_EN
      RD_TS: begin
        if (!avm_waitrequest) begin
          ts_value_n = avm_readdata;
          state_n    = DONE;
          read_n     = 1'b0;
          addr_n     = 1'b0;
          done_n     = 1'b1;
          id_match_n = (id_value == EXPECTED_ID);
          ts_match_n = (avm_readdata == EXPECTED_TIMESTAMP);
        end else if (expire) begin
          state_n    = DONE;
          read_n     = 1'b0;
          addr_n     = 1'b0;
          done_n     = 1'b1;
          timeout_n  = 1'b1;
          id_match_n = 1'b0;
          ts_match_n = 1'b0;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
`endif
      DONE: begin
        if (start) begin
          state_n    = RD_ID;
          read_n     = 1'b1;
          addr_n     = 1'b0;
          done_n     = 1'b0;
          id_match_n = 1'b0;
          ts_match_n = 1'b0;
          timeout_n  = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      boot_q      <= 1'b1;
      cnt_q       <= '0;
      avm_read    <= 1'b0;
      avm_address <= 1'b0;
      done        <= 1'b0;
      id_match    <= 1'b0;
      ts_match    <= 1'b0;
      timeout     <= 1'b0;
      id_value    <= '0;
`ifdef SYSID_CHECKER_TIMESTAMP_EN
      ts_value_q  <= '0;
`endif
    end else begin
      state_q     <= state_n;
      boot_q      <= boot_n;
      cnt_q       <= cnt_n;
      avm_read    <= read_n;
      avm_address <= addr_n;
      done        <= done_n;
      id_match    <= id_match_n;
      ts_match    <= ts_match_n;
      timeout     <= timeout_n;
      id_value    <= id_value_n;
`ifdef SYSID_CHECKER_TIMESTAMP_EN
      ts_value_q  <= ts_value_n;
`endif
    end
  end

endmodule

// File: tb/tb_first_nios2_system_sysid_checker.sv
// Scoreboard bench for first_nios2_system_sysid_checker with a stall-programmable Avalon slave model.
// Expectations adapt to SYSID_CHECKER_TIMESTAMP_EN.
module tb_first_nios2_system_sysid_checker;
`ifdef SYSID_CHECKER_TIMESTAMP_EN
  localparam bit TS = 1'b1;
`else
  localparam bit TS = 1'b0;
`endif
  localparam int EW = 75;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        avm_address, avm_read;
  logic [31:0] avm_readdata = 32'hDEAD_BEEF;
  logic        avm_waitrequest = 1'b0;
  logic        busy, done, id_match, ts_match, timeout;
  logic [31:0] id_value, ts_value;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];

  int          wait_id = 0;
  int          wait_ts = 0;
  logic [31:0] id_word = 32'h0000_1234;
  logic [31:0] ts_word = 32'h50AE_2FFE;

  always #5 clk = ~clk;

  first_nios2_system_sysid_checker dut (
    .clock(clk), .reset(reset), .start(start),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
    .busy(busy), .done(done), .id_match(id_match), .ts_match(ts_match),
    .timeout(timeout), .id_value(id_value), .ts_value(ts_value)
  );

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [EW-1:0] mk(input int lat, input bit idm, input bit tsm, input bit to,
                                       input logic [31:0] idv, input logic [31:0] tsv);
    return {lat[7:0], idm, tsm, to, idv, tsv};
  endfunction

  // Slave model: decides waitrequest/readdata at each falling edge for the next rising edge.
  int   stall = 0;
  logic prev_wr = 1'b0;
  logic prev_addr = 1'b0;
  always @(negedge clk or posedge reset) begin
    if (reset) begin
      stall = 0; prev_wr = 1'b0;
      avm_waitrequest = 1'b0; avm_readdata = 32'hDEAD_BEEF;
    end else begin
      if (prev_wr && avm_read) check("hold_addr", avm_address, prev_addr);
      if (prev_wr && !avm_read) check("hold_read", timeout, 1'b1);
      if (avm_read && stall < (avm_address ? wait_ts : wait_id)) begin
        stall++; avm_waitrequest = 1'b1; avm_readdata = 32'hDEAD_BEEF;
      end else if (avm_read) begin
        stall = 0; avm_waitrequest = 1'b0;
        avm_readdata = avm_address ? ts_word : id_word;
      end else begin
        stall = 0; avm_waitrequest = 1'b0; avm_readdata = 32'hDEAD_BEEF;
      end
      prev_wr   = avm_waitrequest && avm_read;
      prev_addr = avm_address;
    end
  end

  // Monitor: counts busy cycles and checks each completed check against the queue.
  int   lat = 0;
  logic done_prev = 1'b0;
  logic [EW-1:0] e;
  always @(negedge clk) begin
    if (reset) begin
      lat = 0; done_prev = 1'b0;
    end else begin
      if (busy) lat++;
      if (done && !done_prev) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL scoreboard got=unexpected_done exp=none");
        end else begin
          e = exp_q.pop_front();
          check("scoreboard", {lat[7:0], id_match, ts_match, timeout, id_value, ts_value}, e);
        end
        lat = 0;
      end
      done_prev = done;
    end
  end

  task automatic do_reset(input logic [EW-1:0] exp_rec);
    @(negedge clk);
    reset = 1'b1; start = 1'b0;
    exp_q.delete();
    #1 check("reset_state", {avm_read, avm_address, busy, done, id_match, ts_match, timeout,
                             id_value, ts_value}, '0);
    repeat (2) @(negedge clk);
    exp_q.push_back(exp_rec);
    reset = 1'b0;
    @(posedge clk); #1;
    check("boot_read", {avm_read, avm_address, busy}, 3'b101);
  endtask

  task automatic pulse_start(input bit in_done);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    if (in_done) check("restart_clear", {done, id_match, ts_match, timeout, avm_read, busy}, 6'b000011);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    @(negedge clk);
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, done, 1'b1);
  endtask

  initial begin
    int n;
    // Boot check, zero wait states
    do_reset(mk(TS ? 2 : 1, 1, 1, 0, 32'h0000_1234, TS ? 32'h50AE_2FFE : 32'h0));
    wait_done("boot_done");

    // Timestamp mismatch
    ts_word = 32'h50AE_2FFF;
    exp_q.push_back(mk(TS ? 2 : 1, 1, !TS, 0, 32'h0000_1234, TS ? 32'h50AE_2FFF : 32'h0));
    pulse_start(1);
    wait_done("ts_mismatch_done");

    // Three wait states on each read
    ts_word = 32'h50AE_2FFE; wait_id = 3; wait_ts = 3;
    exp_q.push_back(mk(TS ? 8 : 4, 1, 1, 0, 32'h0000_1234, TS ? 32'h50AE_2FFE : 32'h0));
    pulse_start(1);
    wait_done("wait_done");

    // Fresh ID value, start pulsed mid-read is ignored
    id_word = 32'h0000_ABCD; wait_id = 3; wait_ts = 0;
    exp_q.push_back(mk(TS ? 5 : 4, 0, 1, 0, 32'h0000_ABCD, TS ? 32'h50AE_2FFE : 32'h0));
    pulse_start(1);
    pulse_start(0);
    wait_done("ignore_done");

    // Waitrequest stuck high on the ID read right after reset
    id_word = 32'h0000_1234; wait_id = 1000; wait_ts = 0;
    do_reset(mk(16, 0, !TS, 1, 32'h0, 32'h0));
    wait_done("timeout_done");
    check("timeout_read", avm_read, 1'b0);

    // Waitrequest falls on the 16th cycle: acceptance wins
    wait_id = 15;
    exp_q.push_back(mk(TS ? 17 : 16, 1, 1, 0, 32'h0000_1234, TS ? 32'h50AE_2FFE : 32'h0));
    pulse_start(1);
    wait_done("late_accept_done");

    // Reset in the middle of the last read, then rerun from boot
    wait_id = 2; wait_ts = 5;
    pulse_start(1);
    n = 0;
    while (!(busy && (avm_address || !TS)) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("reach_mid", {busy, avm_address}, {1'b1, TS});
    do_reset(mk(TS ? 9 : 3, 1, 1, 0, 32'h0000_1234, TS ? 32'h50AE_2FFE : 32'h0));
    wait_done("reset_rerun_done");

    repeat (5) @(negedge clk);
    check("done_level", done, 1'b1);
    check("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
